// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter and its requesters/memory.
// slave: the arbiter side; master: fetch unit, program loader and memory side.
interface imem_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_stall;
    logic        f_rvalid;
    logic [31:0] f_rdata;

    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_rvalid;
    logic        l_err;
    logic [31:0] l_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        output f_gnt, f_stall, f_rvalid, f_rdata,
        output l_gnt, l_rvalid, l_err, l_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        input  f_gnt, f_stall, f_rvalid, f_rdata,
        input  l_gnt, l_rvalid, l_err, l_rdata,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter: loader has priority, fetch is guaranteed a slot after MAX_BURST loader grants.
// Optional IMEM_ARB_PERF_EN adds saturating stall/load performance counters.
module imem_arbiter #(
    parameter int unsigned MAX_BURST = 8,
    parameter logic [31:0] RESET_PC  = 32'h0100_0000
) (
    input  logic                                 clock,
    input  logic                                 reset,
    imem_arbiter_if.slave                        bus,
    output logic [1:0]                           state,
    output logic [$clog2(MAX_BURST+1)-1:0]       burst_cnt
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]                          perf_stall_cnt,
    output logic [31:0]                          perf_load_cnt
`endif
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   burst_q;
    logic [31:0]        addr_q;
    logic [31:0]        f_rdata_q;
    logic [31:0]        l_rdata_q;
    logic               f_rvalid_q;
    logic               l_rvalid_q;
    logic               l_err_q;

    logic               burst_full;
    logic               f_gnt;
    logic               l_gnt;
    logic               l_misaligned;
    logic [31:0]        mem_addr;

    assign l_misaligned = |bus.l_addr[1:0];
    assign burst_full   = bus.f_req && (burst_q == CNT_W'(MAX_BURST));

    // Grants are blocked while reset is high so nothing reaches memory during reset.
    assign l_gnt = !reset && bus.l_req && !burst_full;
    assign f_gnt = !reset && bus.f_req && !l_gnt;

    always_comb begin
        // NOTE: assign a default first so every path drives mem_addr and no latch is inferred.
        mem_addr = addr_q;
        if (reset)
            mem_addr = RESET_PC;
        else if (f_gnt)
            mem_addr = bus.f_addr & 32'hFFFF_FFFC;
        else if (l_gnt)
            mem_addr = bus.l_addr & 32'hFFFF_FFFC;
    end

    assign bus.f_gnt     = f_gnt;
    assign bus.l_gnt     = l_gnt;
    assign bus.f_stall   = !reset && bus.f_req && !f_gnt;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = l_gnt && bus.l_we && !l_misaligned;
    assign bus.mem_wdata = bus.l_wdata;

    // Read returns are masked during reset so a read issued just before reset never surfaces.
    assign bus.f_rvalid = f_rvalid_q && !reset;
    assign bus.l_rvalid = l_rvalid_q && !reset;
    assign bus.l_err    = l_err_q && !reset;
    assign bus.f_rdata  = reset ? 32'h0 : (f_rvalid_q ? bus.mem_rdata : f_rdata_q);
    assign bus.l_rdata  = reset ? 32'h0 : (l_rvalid_q ? bus.mem_rdata : l_rdata_q);

    assign state     = state_q;
    assign burst_cnt = burst_q;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses <= so every register samples the pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            burst_q    <= '0;
            addr_q     <= RESET_PC;
            f_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            l_err_q    <= 1'b0;
            f_rdata_q  <= 32'h0;
            l_rdata_q  <= 32'h0;
        end else begin
            if (f_gnt)
                state_q <= FETCH;
            else if (l_gnt)
                state_q <= LOAD;
            else
                state_q <= IDLE;

            if (f_gnt || !bus.f_req)
                burst_q <= '0;
            else if (l_gnt && burst_q != CNT_W'(MAX_BURST))
                burst_q <= burst_q + 1'b1;

            addr_q     <= mem_addr;
            f_rvalid_q <= f_gnt;
            l_rvalid_q <= l_gnt && !bus.l_we && !l_misaligned;
            l_err_q    <= l_gnt && l_misaligned;
            f_rdata_q  <= bus.f_rdata;
            l_rdata_q  <= bus.l_rdata;
        end
    end

`ifdef IMEM_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cnt <= 32'h0;
            perf_load_cnt  <= 32'h0;
        end else begin
            if (bus.f_stall && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (l_gnt && perf_load_cnt != 32'hFFFF_FFFF)
                perf_load_cnt <= perf_load_cnt + 32'd1;
        end
    end
`endif
endmodule
